// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_out_reg.sv
// One-entry valid/ready holding register for the selected word and its channel tag.
module scan_mux_out_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SELW-1:0]  load_ch,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [SELW-1:0]  ch,
    output logic             valid,
    output logic             slot_free_c
);

    assign slot_free_c = !valid || ready;

    // A load replaces the held word; without one an accepted word simply drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            ch    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            ch    <= load_ch;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered CH:1 multiplexer with manual select or round-robin scanning with dwell.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*WIDTH-1:0] din,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [WIDTH-1:0]  dout,
    output logic [SELW-1:0]   dout_ch,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d, eff_ptr;
    logic [CNTW-1:0]   cnt_q, cnt_d, eff_cnt;
    logic              load;
    logic [SELW-1:0]   load_ch;
    logic [WIDTH-1:0]  load_data;
    logic              slot_free_c;
    logic [WIDTH-1:0]  ch_data [CH];

    always_comb begin
        for (int k = 0; k < int'(CH); k++) begin
            ch_data[k] = din[k*WIDTH +: WIDTH];
        end
    end

    assign load_data = ch_data[load_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // The mode in effect this cycle decides the capture; state_q only detects scan entry.
    always_comb begin
        state_d = ST_IDLE;
        load    = 1'b0;
        load_ch = '0;
        eff_ptr = ptr_q;
        eff_cnt = cnt_q;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
        if (state_d == ST_SCAN && state_q != ST_SCAN) begin
            eff_ptr = '0;
            eff_cnt = '0;
        end
        ptr_d = eff_ptr;
        cnt_d = eff_cnt;
        unique case (state_d)
            ST_MANUAL: begin
                if (slot_free_c && (32'(sel) < CH)) begin
                    load    = 1'b1;
                    load_ch = sel;
                end
            end
            ST_SCAN: begin
                if (slot_free_c) begin
                    load    = 1'b1;
                    load_ch = eff_ptr;
                    if (eff_cnt == CNTW'(DWELL - 1)) begin
                        cnt_d = '0;
                        ptr_d = (eff_ptr == SELW'(CH - 1)) ? '0 : eff_ptr + 1'b1;
                    end else begin
                        cnt_d = eff_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    scan_mux_out_reg #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_data   (load_data),
        .load_ch     (load_ch),
        .ready       (dout_ready),
        .data        (dout),
        .ch          (dout_ch),
        .valid       (dout_valid),
        .slot_free_c (slot_free_c)
    );

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed literal sequence plus randomized run against a model.
module tb_scan_mux;

    localparam int WIDTH = 8;
    localparam int CH    = 4;
    localparam int DWELL = 2;
    localparam int SELW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH*WIDTH-1:0] din;
    logic [SELW-1:0]     sel;
    logic                mode;
    logic                en;
    logic [WIDTH-1:0]    dout;
    logic [SELW-1:0]     dout_ch;
    logic                dout_valid;
    logic                dout_ready;

    int total = 0;
    int bad   = 0;

    scan_mux #(
        .WIDTH (WIDTH),
        .CH    (CH),
        .DWELL (DWELL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .sel        (sel),
        .mode       (mode),
        .en         (en),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: scan position is the number of scan captures since entering scan.
    logic [WIDTH-1:0] m_data;
    int               m_ch;
    logic             m_valid;
    int               m_k;
    logic             m_prev_scan;

    always @(posedge clk or posedge rst) begin
        bit cap;
        bit free;
        bit scan_now;
        int c;
        if (rst) begin
            m_data = '0; m_ch = 0; m_valid = 1'b0; m_k = 0; m_prev_scan = 1'b0;
        end else begin
            free     = !m_valid || dout_ready;
            scan_now = en && mode;
            if (scan_now && !m_prev_scan) m_k = 0;
            cap = 1'b0;
            c   = 0;
            if (en && !mode && int'(sel) < CH && free) begin
                cap = 1'b1; c = int'(sel);
            end else if (scan_now && free) begin
                cap = 1'b1; c = (m_k / DWELL) % CH; m_k++;
            end
            if (cap) begin
                m_valid = 1'b1; m_ch = c; m_data = din[c*WIDTH +: WIDTH];
            end else if (dout_ready) begin
                m_valid = 1'b0;
            end
            m_prev_scan = scan_now;
        end
    end

    always @(negedge clk) begin
        total++;
        if (dout_valid !== m_valid || dout !== m_data || int'(dout_ch) != m_ch) begin
            bad++;
            $display("FAIL model t=%0t got valid=%b dout=%h ch=%0d want valid=%b dout=%h ch=%0d",
                     $time, dout_valid, dout, dout_ch, m_valid, m_data, m_ch);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string name, input int d, input int c, input int v);
        chk({name, "_dout"}, int'(dout), d);
        chk({name, "_ch"}, int'(dout_ch), c);
        chk({name, "_valid"}, int'(dout_valid), v);
    endtask

    initial begin
        int exp_seq [9];
        exp_seq = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11};

        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd3; dout_ready = 1'b1;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        step(); step();
        chk_out("reset", 0, 0, 0);
        en = 1'b0; rst = 1'b0;
        step(); step();
        chk_out("post_reset_idle", 0, 0, 0);

        // Manual selection
        en = 1'b1; mode = 1'b0; sel = 2'd2;
        step(); chk_out("manual_sel2", 'h33, 2, 1);
        sel = 2'd1;
        step(); chk_out("manual_sel1", 'h22, 1, 1);
        sel = 2'd0;
        step(); chk_out("manual_sel0", 'h11, 0, 1);
        dout_ready = 1'b0; sel = 2'd3;
        step(); step(); chk_out("manual_frozen", 'h11, 0, 1);

        // Scan sequence
        mode = 1'b1; dout_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk_out($sformatf("scan%0d", i), exp_seq[i], (i / DWELL) % CH, 1);
        end

        // Backpressure
        en = 1'b0;
        step();
        en = 1'b1;
        step(); step(); step();
        chk_out("bp_first22", 'h22, 1, 1);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out($sformatf("bp_hold%0d", i), 'h22, 1, 1);
        end
        dout_ready = 1'b1;
        step(); chk_out("bp_rel0", 'h22, 1, 1);
        step(); chk_out("bp_rel1", 'h33, 2, 1);
        step(); chk_out("bp_rel2", 'h33, 2, 1);

        // Async reset mid-scan
        rst = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0);
        #3 rst = 1'b0;
        step(); chk_out("after_rst_scan", 'h11, 0, 1);

        // Disable under stall
        for (int i = 0; i < 6; i++) step();
        chk_out("stall_44", 'h44, 3, 1);
        dout_ready = 1'b0; en = 1'b0;
        step(); step(); chk_out("disable_hold", 'h44, 3, 1);
        dout_ready = 1'b1;
        step(); chk_out("disable_drain", 'h44, 3, 0);
        step(); chk_out("disable_idle", 'h44, 3, 0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            din = {$urandom, $urandom};
            sel = SELW'($urandom_range(0, CH - 1));
            dout_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel multiplexer that succeeds the team's combinational 4:1 mux. It selects one of `CH` input words of `WIDTH` bits, either from an external select (manual mode) or by round-robin scanning with a programmable dwell. It presents the result on a valid/ready output register. It sits between parallel sensor/data lanes and a single downstream consumer.

## Interface
- `WIDTH`, 8: data word width in bits (≥1)
- `CH`, 4: number of input channels (≥2)
- `DWELL`, 4: accepted samples per channel before the scan advances (≥1)
- `SELW`, `$clog2(CH)`: select/channel-index width (derived; not overridden)

- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `din` input `CH*WIDTH`: flattened channel data; channel k occupies `[k*WIDTH +: WIDTH]`
- `sel` input `SELW`: channel select, used in manual mode
- `mode` input 1: 0 = manual, 1 = scan
- `en` input 1: capture enable
- `dout` output `WIDTH`: selected data word (registered)
- `dout_ch` output `SELW`: index of the channel that produced `dout`
- `dout_valid` output 1: `dout`/`dout_ch` hold an unconsumed word
- `dout_ready` input 1: consumer accepts the word on this cycle when `dout_valid=1`

## Operation
- Slot free = `!dout_valid || dout_ready`. A capture happens only when the slot is free and a capture condition holds.
- FSM states are IDLE, MANUAL and SCAN, evaluated every cycle:
  - `en=0` → IDLE
  - `en=1, mode=0` → MANUAL
  - `en=1, mode=1` → SCAN
- IDLE: no capture. A held valid word stays until accepted, then `dout_valid` falls. `dout` retains its last value.
- MANUAL: on a free slot with `sel<CH`, capture `din[sel]` and set `dout_ch=sel`, `dout_valid=1`. With `sel≥CH`, no capture occurs; the current word drains normally.
- SCAN: uses pointer `ptr` (SELW bits) and dwell counter `cnt` (0..DWELL-1).
  - On a free slot, capture `din[ptr]` and set `dout_ch=ptr`.
  - After each capture, `cnt` increments. When `cnt==DWELL-1`, `cnt` returns to 0 and `ptr` advances, wrapping from `CH-1` to 0.
  - Any transition into SCAN from another state loads `ptr=0`, `cnt=0` before the first capture.
  - MANUAL captures do not modify `ptr`/`cnt`.
- Stall: while `dout_valid=1 && dout_ready=0`, `dout`, `dout_ch` and `dout_valid` are frozen, and `ptr`/`cnt` do not advance. No sample is skipped.
- `dout_valid` never drops without a handshake, except on reset.

## Timing
- Reset (async assert, sync release) sets:
  - outputs: `dout=0`, `dout_ch=0`, `dout_valid=0`
  - internal state: `ptr=0`, `cnt=0`, state IDLE
- Reset mid-transfer discards the held word immediately.
- Capture latency is 1 cycle: `din`/`sel` sampled at edge n appear on `dout` after edge n.
- Throughput is 1 word/cycle with `dout_ready` held high.
- Simultaneous accept and capture in the same cycle: the new word replaces the old one with `dout_valid` staying 1 (no bubble).
- A mode change takes effect on the next capture. The word already in the register is unaffected.
- `DWELL=1`: `ptr` advances on every capture.

## Structure
- Package `scan_mux_pkg` holds:
  - state enum (IDLE/MANUAL/SCAN)
  - mode constants `MODE_MANUAL=0`, `MODE_SCAN=1`
- One natural sub-module: `scan_mux_out_reg`, a one-entry valid/ready holding register (WIDTH+SELW payload) providing the slot-free signal.
- Channel selection, FSM and scan counters stay in the top level.

## Test plan
Configuration: WIDTH=8, CH=4, DWELL=2; `din` ch0..ch3 = 0x11, 0x22, 0x33, 0x44.
- Reset: `rst=1` with arbitrary inputs → `dout=0x00`, `dout_ch=0`, `dout_valid=0`. Released with `en=0` → outputs remain reset values.
- Manual: `en=1`, `mode=0`, `ready=1`, `sel=2` then `sel=1` → after edge 1: 0x33/ch2/valid; after edge 2: 0x22/ch1. Then `sel=0`, `ready=0` → word frozen at 0x11/ch0.
- Scan sequence: `en=1`, `mode=1`, `ready=1` for 9 cycles → `dout` = 11,11,22,22,33,33,44,44,11 and `dout_ch` = 0,0,1,1,2,2,3,3,0.
- Backpressure: in scan, `ready=0` for 3 cycles after the first 0x22 → `dout` holds 0x22/ch1. On release, sequence continues 22,33,33 with no skip or duplicate.
- Async reset mid-scan: assert `rst` between edges while `dout_ch=2` → `dout_valid`/`dout` clear before the next edge. After release in scan, the first word is 0x11/ch0.
- Disable under stall: valid 0x44 with `ready=0`, then `en=0` → word held. When `ready=1` for one cycle, `dout_valid` falls next cycle and no new capture follows.
